tick_timeout_monitor: RTL



---
 rtl/tick_mon_pkg.sv | 18 +
 rtl/tick_edge_detect.sv | 44 ++++
 rtl/tick_timeout_monitor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tick_mon_pkg.sv
//-----------------------------------------------------------------------------
// tick_mon_pkg
//
// Constants shared by the tick timeout monitor and its sub-modules:
//   - FSM state encoding (kept as plain localparams so older tools and
//     waveform viewers see stable 2-bit codes)
//   - default TIMEOUT_TICKS / CNT_W values used by the top-level parameters
//-----------------------------------------------------------------------------
package tick_mon_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    localparam int DEFAULT_TIMEOUT_TICKS = 8;
    localparam int DEFAULT_CNT_W         = 8;

endpackage : tick_mon_pkg

// File: rtl/tick_edge_detect.sv
//-----------------------------------------------------------------------------
// tick_edge_detect
//
// Brings an asynchronous slow clock (or any slow level) into the clk domain
// through a two-flop synchronizer and emits a one-cycle pulse on each rising
// edge. All three flops reset to 1, so an input that is already high when
// reset is released does not look like a rising edge.
//
// Ports:
//   clk     in   fast sampling clock
//   rst     in   synchronous reset, active-high
//   sig_in  in   asynchronous input level
//   rise    out  one-cycle pulse, two clk edges after sig_in is first
//                sampled high (combinational from flops)
//-----------------------------------------------------------------------------
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic s1;   // metastability catch flop
    logic s2;   // synchronized level
    logic s3;   // previous synchronized level

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would collapse the
    // synchronizer chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule : tick_edge_detect

// File: rtl/tick_timeout_monitor.sv
//-----------------------------------------------------------------------------
// tick_timeout_monitor
//
// Times out a bus transaction in units of slow-clock ticks. The arbiter arms
// the monitor when it issues a grant; the slave ack disarms it. If
// TIMEOUT_TICKS ticks elapse first, timeout_o is held high until the arbiter
// re-arms or the ack finally arrives, letting the arbiter reclaim the bus.
//
// Parameters:
//   TIMEOUT_TICKS  ticks allowed between arm and ack (1 .. 2**CNT_W-1)
//   CNT_W          width of the tick counter
//
// Ports:
//   inclk         in   fast system clock
//   rst           in   synchronous reset, active-high
//   slow_clk_in   in   divided clock, treated as asynchronous data
//   arm_i         in   one-cycle pulse: start or restart timing
//   ack_i         in   slave completion, sampled every cycle
//   tick_o        out  one-cycle pulse per slow_clk_in rising edge
//   active_o      out  high while ARMED
//   timeout_o     out  high while EXPIRED
//   done_o        out  one-cycle pulse when ack ends an ARMED window
//   tick_count_o  out  ticks elapsed in the current window
//   exp_count_o   out  saturating count of expiries (only when the macro
//                      TICK_MON_EXPCNT_EN is defined)
//-----------------------------------------------------------------------------
module tick_timeout_monitor
    import tick_mon_pkg::*;
#(
    parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             inclk,
    input  logic             rst,
    input  logic             slow_clk_in,
    input  logic             arm_i,
    input  logic             ack_i,
    output logic             tick_o,
    output logic             active_o,
    output logic             timeout_o,
    output logic             done_o,
    output logic [CNT_W-1:0] tick_count_o
`ifdef TICK_MON_EXPCNT_EN
   ,output logic [7:0]       exp_count_o
`endif
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(TIMEOUT_TICKS);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] count_d;
    logic             done_d;
    logic             expire_d;   // ARMED -> EXPIRED this cycle

    tick_edge_detect u_edge (
        .clk    (inclk),
        .rst    (rst),
        .sig_in (slow_clk_in),
        .rise   (tick_o)
    );

    // Next-state logic. In ARMED the priority is arm > ack > tick, so an ack
    // arriving with the expiring tick completes the transaction cleanly.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = tick_count_o;
        done_d   = 1'b0;
        expire_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_i) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            ARMED: begin
                if (arm_i) begin
                    count_d = '0;
                end else if (ack_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick_o) begin
                    if (tick_count_o == LAST_COUNT) begin
                        state_d  = EXPIRED;
                        count_d  = FULL_COUNT;
                        expire_d = 1'b1;
                    end else begin
                        count_d = tick_count_o + CNT_W'(1);
                    end
                end
            end
            EXPIRED: begin
                // Count stays frozen at TIMEOUT_TICKS; ticks are ignored.
                if (arm_i) begin
                    state_d = ARMED;
                    count_d = '0;
                end else if (ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with state_q and never glitch.
    always_ff @(posedge inclk) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_count_o <= '0;
            active_o     <= 1'b0;
            timeout_o    <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_count_o <= count_d;
            active_o     <= (state_d == ARMED);
            timeout_o    <= (state_d == EXPIRED);
            done_o       <= done_d;
        end
    end

`ifdef TICK_MON_EXPCNT_EN
    // Saturates rather than wraps so a long-running count never looks small.
    always_ff @(posedge inclk) begin
        if (rst) begin
            exp_count_o <= 8'd0;
        end else if (expire_d && (exp_count_o != 8'hFF)) begin
            exp_count_o <= exp_count_o + 8'd1;
        end
    end
`endif

endmodule : tick_timeout_monitor
